dff_checker: RTL and testbench

DFF_CHECKER -- requirements
Module: dff_checker

---
 rtl/dff_chk_pkg.sv | 14 +
 rtl/sat_counter.sv | 24 ++
 rtl/dff_checker.sv | 126 ++++++++++++
 tb/tb_dff_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_chk_pkg.sv
// Shared definitions for the flip-flop checker: state encoding and default widths.
package dff_chk_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned CYC_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dff_checker.sv
// Checks a D flip-flop with active-high clear against a one-register reference model.
// Define DFF_CHK_STICKY_EN to end a run on the first failed compare.
module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             d_obs,
  input  logic             clr_obs,
  input  logic             q_obs,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic [1:0]       state,
  output logic             done
);

  logic [1:0] rst_sync;
  logic       rst_n;
  state_t     state_nxt;
  logic       start_acc;
  logic       cmp_fail;
  logic       exp;
  logic [CYC_W-1:0] cyc;

  // Reset asserts immediately, releases two edges later so the FSM leaves reset cleanly
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    cmp_fail  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WARM;
          start_acc = 1'b1;
        end
      end
      ST_WARM: begin
        state_nxt = stop ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        cmp_fail = (q_obs != exp);
        if (stop) begin
          state_nxt = ST_DONE;
        end
`ifdef DFF_CHK_STICKY_EN
        else if (cmp_fail) begin
          state_nxt = ST_DONE;
        end
`else
        else begin
          state_nxt = ST_CHECK;
        end
`endif
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_WARM;
          start_acc = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reference model, cycle counter and first-error timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp           <= 1'b0;
      cyc           <= '0;
      first_err_cyc <= '0;
      mismatch      <= 1'b0;
      done          <= 1'b0;
    end else begin
      mismatch <= cmp_fail;
      done     <= (state_nxt == ST_DONE);
      if (start_acc) begin
        exp           <= 1'b0;
        cyc           <= '0;
        first_err_cyc <= '0;
      end else if ((state == ST_WARM) || (state == ST_CHECK)) begin
        exp <= clr_obs ? 1'b0 : d_obs;
        cyc <= cyc + CYC_W'(1);
        if (cmp_fail && (err_count == '0)) begin
          first_err_cyc <= cyc;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .inc   (cmp_fail),
    .count (err_count)
  );

endmodule

// File: tb/tb_dff_checker.sv
// Randomised self-checking bench for dff_checker with a cycle-level behavioural model.
module tb_dff_checker;

`ifdef DFF_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, d_obs = 1'b0, clr_obs = 1'b0, q_obs = 1'b0;

  logic        mismatch, done;
  logic [7:0]  err_count;
  logic [15:0] first_err_cyc;
  logic [1:0]  state;
  logic        s_mismatch, s_done;
  logic [3:0]  s_err;
  logic [15:0] s_first;
  logic [1:0]  s_state;

  int checks = 0;
  int failures = 0;
  int mis_seen = 0;

  // Model: phase 0..3 = IDLE/WARM/CHECK/DONE
  int m_state = 0, m_err = 0, m_err4 = 0, m_first = 0, m_cyc = 0, m_hold = 0;
  bit m_exp = 1'b0, m_mis = 1'b0;

  always #5 clk = ~clk;

  dff_checker u_dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .d_obs(d_obs), .clr_obs(clr_obs), .q_obs(q_obs),
    .mismatch(mismatch), .err_count(err_count), .first_err_cyc(first_err_cyc),
    .state(state), .done(done)
  );

  dff_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .d_obs(d_obs), .clr_obs(clr_obs), .q_obs(q_obs),
    .mismatch(s_mismatch), .err_count(s_err), .first_err_cyc(s_first),
    .state(s_state), .done(s_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".state"}, 32'(state), 32'(m_state));
    check_eq({tag, ".done"}, 32'(done), 32'(m_state == 3));
    check_eq({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
    check_eq({tag, ".err"}, 32'(err_count), 32'(m_err));
    check_eq({tag, ".first"}, 32'(first_err_cyc), 32'(m_first));
    check_eq({tag, ".sat_err"}, 32'(s_err), 32'(m_err4));
    check_eq({tag, ".sat_state"}, 32'(s_state), 32'(m_state));
    if (mismatch === 1'b1) mis_seen++;
  endtask

  task automatic model_step(input bit s, input bit p, input bit d, input bit c, input bit q);
    bit acc, fail;
    int nst;
    if (m_hold > 0) begin
      m_hold--;
      m_mis = 1'b0;
      return;
    end
    acc  = (m_state == 0 || m_state == 3) && s;
    fail = (m_state == 2) && (q != m_exp);
    nst  = m_state;
    case (m_state)
      0: if (s) nst = 1;
      1: nst = p ? 3 : 2;
      2: if (p || (STICKY && fail)) nst = 3;
      default: if (s) nst = 1;
    endcase
    if (acc) begin
      m_exp = 1'b0; m_err = 0; m_err4 = 0; m_first = 0; m_cyc = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (fail) begin
        if (m_err == 0) m_first = m_cyc;
        if (m_err < 255) m_err++;
        if (m_err4 < 15) m_err4++;
      end
      m_cyc = (m_cyc + 1) % 65536;
      m_exp = c ? 1'b0 : d;
    end
    m_mis   = fail;
    m_state = nst;
  endtask

  // One clock: drive inputs, advance model, sample just after the edge
  task automatic step(input bit s, input bit p, input bit d, input bit c, input bit bad);
    bit q;
    q = m_exp ^ bad;
    start = s; stop = p; d_obs = d; clr_obs = c; q_obs = q;
    model_step(s, p, d, c, q);
    @(posedge clk);
    #1;
    compare_all("cyc");
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    m_state = 0; m_err = 0; m_err4 = 0; m_first = 0; m_cyc = 0;
    m_exp = 1'b0; m_mis = 1'b0; m_hold = 0;
    compare_all("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    clr_n = 1'b1;
    m_hold = 2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    idle(3);

    // Clean run: D toggles every two cycles, Q follows the model
    mis_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'((i / 2) % 2), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("clean_err", 32'(err_count), 32'd0);
    check_eq("clean_done", 32'(done), 32'd1);
    check_eq("clean_pulses", 32'(mis_seen), 32'd0);
    idle(2);

    // Single error at cycle index 7
    mis_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, (m_state == 2) && (m_cyc == 7));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("single_err", 32'(err_count), 32'd1);
    check_eq("single_first", 32'(first_err_cyc), 32'd7);
    check_eq("single_pulses", 32'(mis_seen), 32'd1);

    // Clear dominates D: Q low matches, Q high fails every cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("clr_q0_err", 32'(err_count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      q_obs = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1, m_exp == 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("clr_q1_err", 32'(err_count), STICKY ? 32'd1 : 32'd3);

    // Saturation: 20 consecutive failures
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sat4_err", 32'(s_err), STICKY ? 32'd1 : 32'd15);
    check_eq("sat8_err", 32'(err_count), STICKY ? 32'd1 : 32'd20);
    check_eq("sat_state", 32'(state), 32'd3);

    // Start and stop together in CHECK, then in WARM
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, !STICKY && (i < 2));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ss_check_state", 32'(state), 32'd3);
    check_eq("ss_check_err", 32'(err_count), STICKY ? 32'd0 : 32'd2);
    check_eq("ss_check_first", 32'(first_err_cyc), STICKY ? 32'd0 : 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ss_warm_state", 32'(state), 32'd3);
    check_eq("ss_warm_err", 32'(err_count), 32'd0);

    // Reset in the fifth CHECK cycle, then a clean run
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, i == 1);
    do_reset();
    check_eq("mid_rst_state", 32'(state), 32'd0);
    check_eq("mid_rst_err", 32'(err_count), 32'd0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_err", 32'(err_count), 32'd0);
    check_eq("post_rst_done", 32'(done), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
